// File: rtl/normal_probe_sequencer.sv
// normal_probe_sequencer: shares one sceneQuery engine across the four
// tetrahedron normal probes (xyy, yxy, yyx, xxx). One surface point is
// accepted per transaction. Each probe position is issued in turn, and the
// engine's variable-latency result is awaited before the next probe. The
// four distances and the latched point are then presented as one bundle.
// Vec3 packing for p, q_pos and p_out is {x, y, z}, with x in bits [95:64].
module normal_probe_sequencer #(
    parameter logic [31:0] EPS     = 32'h0000_4189,  // Q8.24 probe offset
    parameter int unsigned TIMEOUT = 64               // max wait cycles, 2..255
) (
    input  logic        clk,
    input  logic        rst,

    // Request side
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [95:0] p,
    input  logic        hit_in,
    input  logic        obj_sel,

    // sceneQuery side
    output logic        q_valid,
    output logic [95:0] q_pos,
    output logic        q_obj_sel,
    input  logic        q_done,
    input  logic [31:0] q_dist,

    // Result bundle
    output logic        valid_out,
    input  logic        out_ready,
    output logic [31:0] d_xyy,
    output logic [31:0] d_yxy,
    output logic [31:0] d_yyx,
    output logic [31:0] d_xxx,
    output logic [95:0] p_out,
    output logic        hit_out,
    output logic        timeout_out
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Counter value at which one more empty WAIT cycle means the query has
    // taken TIMEOUT cycles.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [95:0]       p_q, p_d;
    logic              hit_q, hit_d;
    logic              obj_q, obj_d;
    logic              tmo_q, tmo_d;
    // Slot order: [0]=xyy, [1]=yxy, [2]=yyx, [3]=xxx
    logic [3:0][31:0]  dist_q, dist_d;

    // Probe component arithmetic: wrapping two's-complement add/sub
    logic [31:0] x_pl, x_mi, y_pl, y_mi, z_pl, z_mi;
    logic        neg_x, neg_y, neg_z;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= 2'd0;
            cnt_q   <= 8'd0;
            p_q     <= '0;
            hit_q   <= 1'b0;
            obj_q   <= 1'b0;
            tmo_q   <= 1'b0;
            dist_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            hit_q   <= hit_d;
            obj_q   <= obj_d;
            tmo_q   <= tmo_d;
            dist_q  <= dist_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        hit_d   = hit_q;
        obj_d   = obj_q;
        tmo_d   = tmo_q;
        dist_d  = dist_q;

        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    p_d    = p;
                    hit_d  = hit_in;
                    obj_d  = obj_sel;
                    tmo_d  = 1'b0;
                    dist_d = '0;
                    k_d    = 2'd0;
                    // Misses skip the query engine and report zero distances
                    state_d = hit_in ? StIssue : StDone;
                end
            end

            StIssue: begin
                cnt_d   = 8'd0;
                state_d = StWait;
            end

            StWait: begin
                // A result arriving in the timeout cycle still counts
                if (q_done) begin
                    dist_d[k_q] = q_dist;
                    if (k_q == 2'd3) begin
                        state_d = StDone;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = StIssue;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == WaitLast) begin
                        dist_d  = '0;
                        tmo_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // Offset components for the latched point
    always_comb begin
        x_pl = p_q[95:64] + EPS;
        x_mi = p_q[95:64] - EPS;
        y_pl = p_q[63:32] + EPS;
        y_mi = p_q[63:32] - EPS;
        z_pl = p_q[31:0]  + EPS;
        z_mi = p_q[31:0]  - EPS;
    end

    // Probe sign selection: xyy(+,-,-) yxy(-,+,-) yyx(-,-,+) xxx(+,+,+)
    always_comb begin
        neg_x = (k_q == 2'd1) || (k_q == 2'd2);
        neg_y = (k_q == 2'd0) || (k_q == 2'd2);
        neg_z = (k_q == 2'd0) || (k_q == 2'd1);
    end

    // Query interface; q_pos is held from issue until the result returns
    always_comb begin
        q_valid   = (state_q == StIssue);
        q_obj_sel = obj_q;
        q_pos     = '0;
        if ((state_q == StIssue) || (state_q == StWait)) begin
            q_pos = {neg_x ? x_mi : x_pl,
                     neg_y ? y_mi : y_pl,
                     neg_z ? z_mi : z_pl};
        end
    end

    // Request handshake and result bundle
    always_comb begin
        ready_in    = (state_q == StIdle);
        valid_out   = (state_q == StDone);
        d_xyy       = dist_q[0];
        d_yxy       = dist_q[1];
        d_yyx       = dist_q[2];
        d_xxx       = dist_q[3];
        p_out       = p_q;
        hit_out     = hit_q;
        timeout_out = tmo_q;
    end

endmodule

// File: tb/tb_normal_probe_sequencer.sv
// Scoreboard bench for normal_probe_sequencer: stimulus pushes the expected
// probe issues and result bundles; a monitor pops and compares them as the
// DUT presents q_valid and valid_out.
`timescale 1ns/1ps
module tb_normal_probe_sequencer;

    localparam logic [31:0] EPS = 32'h0000_4189;
    localparam int          TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [95:0] p = '0;
    logic        hit_in = 1'b0;
    logic        obj_sel = 1'b0;
    logic        q_valid;
    logic [95:0] q_pos;
    logic        q_obj_sel;
    logic        q_done;
    logic [31:0] q_dist;
    logic        valid_out;
    logic        out_ready = 1'b1;
    logic [31:0] d_xyy, d_yxy, d_yyx, d_xxx;
    logic [95:0] p_out;
    logic        hit_out;
    logic        timeout_out;

    logic        mdl_done = 1'b0;
    logic [31:0] mdl_dist = '0;
    logic        late_done = 1'b0;
    logic [31:0] late_dist = '0;

    assign q_done = mdl_done | late_done;
    assign q_dist = late_done ? late_dist : mdl_dist;

    normal_probe_sequencer #(
        .EPS     (EPS),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .p           (p),
        .hit_in      (hit_in),
        .obj_sel     (obj_sel),
        .q_valid     (q_valid),
        .q_pos       (q_pos),
        .q_obj_sel   (q_obj_sel),
        .q_done      (q_done),
        .q_dist      (q_dist),
        .valid_out   (valid_out),
        .out_ready   (out_ready),
        .d_xyy       (d_xyy),
        .d_yxy       (d_yxy),
        .d_yyx       (d_yyx),
        .d_xxx       (d_xxx),
        .p_out       (p_out),
        .hit_out     (hit_out),
        .timeout_out (timeout_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] pos;
        logic        obj;
        int          rel;
    } probe_t;

    typedef struct {
        logic [31:0] d0, d1, d2, d3;
        logic [95:0] p;
        logic        hit;
        logic        tmo;
        int          lat;
    } res_t;

    probe_t pq[$];
    res_t   rq[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;

    // sceneQuery model controls
    int lat = 3;
    int sup_k = -1;
    int mdl_k = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [95:0] probe_pos(input logic [95:0] pv, input int k);
        logic [31:0] x, y, z;
        x = (k == 1 || k == 2) ? pv[95:64] - EPS : pv[95:64] + EPS;
        y = (k == 0 || k == 2) ? pv[63:32] - EPS : pv[63:32] + EPS;
        z = (k == 0 || k == 1) ? pv[31:0]  - EPS : pv[31:0]  + EPS;
        return {x, y, z};
    endfunction

    // sceneQuery model: answers L cycles after q_valid with 0x100*(k+1)
    initial begin : model
        int kk;
        forever begin
            @(negedge clk);
            mdl_done = 1'b0;
            if (q_valid && !rst) begin
                kk = mdl_k;
                mdl_k++;
                if (kk != sup_k) begin
                    repeat (lat) @(negedge clk);
                    mdl_done = 1'b1;
                    mdl_dist = 32'((kk + 1) * 256);
                end
            end
        end
    end

    // Monitor: compares probe issues and result bundles against the queues
    res_t cur;
    logic have_cur = 1'b0;
    logic vo_prev = 1'b0;
    logic pend_rel = 1'b0;

    initial begin : monitor
        probe_t pe;
        forever begin
            @(negedge clk);
            if (rst) begin
                vo_prev  = 1'b0;
                pend_rel = 1'b0;
                have_cur = 1'b0;
            end else begin
                if (pend_rel) begin
                    check("release_ready_in", 96'(ready_in), 96'(1));
                    check("release_valid_out", 96'(valid_out), 96'(0));
                    pend_rel = 1'b0;
                end
                if (valid_in && ready_in) acc_cyc = cyc;
                if (q_valid) begin
                    check("probe_expected", 96'(pq.size() != 0), 96'(1));
                    if (pq.size() != 0) begin
                        pe = pq.pop_front();
                        check("probe_cycle", 96'(cyc - acc_cyc), 96'(pe.rel));
                        check("probe_q_pos", q_pos, pe.pos);
                        check("probe_q_obj_sel", 96'(q_obj_sel), 96'(pe.obj));
                    end
                end
                if (valid_out) begin
                    if (!vo_prev) begin
                        check("result_expected", 96'(rq.size() != 0), 96'(1));
                        if (rq.size() != 0) begin
                            cur = rq.pop_front();
                            have_cur = 1'b1;
                            check("result_latency", 96'(cyc - acc_cyc), 96'(cur.lat));
                        end
                    end
                    if (have_cur) begin
                        check("d_xyy", 96'(d_xyy), 96'(cur.d0));
                        check("d_yxy", 96'(d_yxy), 96'(cur.d1));
                        check("d_yyx", 96'(d_yyx), 96'(cur.d2));
                        check("d_xxx", 96'(d_xxx), 96'(cur.d3));
                        check("p_out", p_out, cur.p);
                        check("hit_out", 96'(hit_out), 96'(cur.hit));
                        check("timeout_out", 96'(timeout_out), 96'(cur.tmo));
                    end
                    if (out_ready) begin
                        pend_rel = 1'b1;
                        have_cur = 1'b0;
                    end
                end
                vo_prev = valid_out;
            end
        end
    end

    // Queue expectations and issue one request; returns in cycle 1
    task automatic send(input logic [95:0] pv, input logic hv, input logic ov,
                        input int l, input int sup, input logic [95:0] pos0);
        res_t   r;
        probe_t e;
        lat   = l;
        sup_k = sup;
        mdl_k = 0;
        if (hv) begin
            for (int k = 0; k < 4; k++) begin
                if (sup >= 0 && k > sup) break;
                e.pos = (k == 0) ? pos0 : probe_pos(pv, k);
                e.obj = ov;
                e.rel = 1 + k * (l + 1);
                pq.push_back(e);
            end
        end
        r.p   = pv;
        r.hit = hv;
        r.d0  = '0;
        r.d1  = '0;
        r.d2  = '0;
        r.d3  = '0;
        r.tmo = 1'b0;
        if (!hv) begin
            r.lat = 1;
        end else if (sup >= 0) begin
            r.tmo = 1'b1;
            r.lat = 1 + sup * (l + 1) + TMO + 1;
        end else begin
            r.d0  = 32'h100;
            r.d1  = 32'h200;
            r.d2  = 32'h300;
            r.d3  = 32'h400;
            r.lat = 4 * l + 5;
        end
        rq.push_back(r);
        p        = pv;
        hit_in   = hv;
        obj_sel  = ov;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            step();
            n++;
            ok = ready_in && !valid_out && (rq.size() == 0) && (pq.size() == 0);
        end
        check("drain_within_budget", 96'(ok), 96'(1));
        repeat (2) step();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ready_in"}, 96'(ready_in), 96'(1));
        check({tag, "_q_valid"}, 96'(q_valid), 96'(0));
        check({tag, "_q_pos"}, q_pos, 96'(0));
        check({tag, "_q_obj_sel"}, 96'(q_obj_sel), 96'(0));
        check({tag, "_valid_out"}, 96'(valid_out), 96'(0));
        check({tag, "_dists"}, {d_xyy, d_yxy, d_yyx}, 96'(0));
        check({tag, "_d_xxx"}, 96'(d_xxx), 96'(0));
        check({tag, "_p_out"}, p_out, 96'(0));
        check({tag, "_hit_out"}, 96'(hit_out), 96'(0));
        check({tag, "_timeout_out"}, 96'(timeout_out), 96'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        repeat (3) step();
        check_cleared("reset");
        rst = 1'b0;
        step();

        // Hit, L=3, hand-computed first probe
        send({32'h0100_0000, 32'h0200_0000, 32'hFF80_0000}, 1'b1, 1'b1, 3, -1,
             {32'h0100_4189, 32'h01FF_BE77, 32'hFF7F_BE77});
        wait_idle(100);

        // Miss bypass: no probe expected, result at cycle 1
        send({32'h0300_0000, 32'h0400_0000, 32'h0500_0000}, 1'b0, 1'b1, 3, -1, '0);
        wait_idle(50);

        // Shortest latency
        send({32'h0000_0000, 32'hFFFF_0000, 32'h1234_5678}, 1'b1, 1'b0, 1, -1,
             {32'h0000_4189, 32'hFFFE_BE77, 32'h1234_14EF});
        wait_idle(100);

        // Result in the same cycle the timeout would fire: capture wins
        send({32'h0010_0000, 32'h0020_0000, 32'h0030_0000}, 1'b1, 1'b0, TMO, -1,
             {32'h0010_4189, 32'h001F_BE77, 32'h002F_BE77});
        wait_idle(200);

        // Backpressure with ignored requests during WAIT and DONE
        out_ready = 1'b0;
        send({32'h0101_0101, 32'h0202_0202, 32'h0303_0303}, 1'b1, 1'b1, 3, -1,
             probe_pos({32'h0101_0101, 32'h0202_0202, 32'h0303_0303}, 0));
        repeat (2) step();
        p        = {32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC};
        obj_sel  = 1'b0;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        n = 0;
        while (!valid_out && n < 100) begin
            step();
            n++;
        end
        check("backpressure_valid_out_seen", 96'(valid_out), 96'(1));
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        repeat (9) step();
        check("backpressure_ready_held_low", 96'(ready_in), 96'(0));
        out_ready = 1'b1;
        wait_idle(50);

        // Timeout on probe 2, then a late result in IDLE
        send({32'h0500_0000, 32'h0600_0000, 32'h0700_0000}, 1'b1, 1'b1, 3, 2,
             probe_pos({32'h0500_0000, 32'h0600_0000, 32'h0700_0000}, 0));
        wait_idle(100);
        late_dist = 32'hDEAD_BEEF;
        late_done = 1'b1;
        step();
        late_done = 1'b0;
        step();
        check("late_done_ready_in", 96'(ready_in), 96'(1));
        check("late_done_valid_out", 96'(valid_out), 96'(0));
        check("late_done_q_valid", 96'(q_valid), 96'(0));
        check("late_done_d_yyx", 96'(d_yyx), 96'(0));
        send({32'h0800_0000, 32'h0900_0000, 32'h0A00_0000}, 1'b1, 1'b0, 2, -1,
             probe_pos({32'h0800_0000, 32'h0900_0000, 32'h0A00_0000}, 0));
        wait_idle(100);

        // Reset during probe 1 WAIT
        send({32'h0B00_0000, 32'h0C00_0000, 32'h0D00_0000}, 1'b1, 1'b1, 3, -1,
             probe_pos({32'h0B00_0000, 32'h0C00_0000, 32'h0D00_0000}, 0));
        repeat (5) step();
        check("pre_reset_d_xyy", 96'(d_xyy), 96'(32'h100));
        rst = 1'b1;
        #1;
        check_cleared("midwait_reset");
        pq.delete();
        rq.delete();
        step();
        step();
        rst = 1'b0;
        repeat (6) step();
        wait_idle(50);
        send({32'h0E00_0000, 32'h0F00_0000, 32'h1000_0000}, 1'b1, 1'b1, 3, -1,
             probe_pos({32'h0E00_0000, 32'h0F00_0000, 32'h1000_0000}, 0));
        wait_idle(100);

        // Wrap-around on all three components of xyy
        send({32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000}, 1'b1, 1'b1, 2, -1,
             {32'h8000_4188, 32'hFFFF_BE77, 32'h7FFF_BE77});
        wait_idle(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
